// File: rtl/dff_pipe.sv
// dff_pipe: enabled register pipeline with one valid bit per stage and a
// registered occupancy count. It replaces the single enabled D flip-flop in
// datapaths that need delay matching or retiming.
//
// Parameters:
//   WIDTH     data width in bits (>= 1)
//   DEPTH     number of register stages (>= 1)
//   HOLD_MODE behaviour while en=0: 1 = every stage holds, 0 = every stage clears
//   RESET_VAL value loaded into every data stage on reset, flush or clear
//
// Ports:
//   clk     clock; all state changes on the rising edge
//   rst     synchronous active-high reset
//   en      stage enable; the pipeline shifts by one stage when high
//   flush   synchronous invalidate of all stages; the input word on that edge is dropped
//   d       data into stage 0
//   d_valid marks d as valid
//   q       data of the last stage (not masked by q_valid)
//   q_valid valid bit of the last stage
//   count   number of stages holding a valid bit, 0..DEPTH
//
// Handshake: there is no backpressure. A word enters whenever en=1 and
// d_valid=1. The consumer must take q on every edge where q_valid=1 and en=1,
// because that word leaves the pipeline on that edge.
//
// Edge priority: rst > flush > en. Every output comes straight from a register.
module dff_pipe #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter bit               HOLD_MODE = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           d,
  input  logic                       d_valid,
  output logic [WIDTH-1:0]           q,
  output logic                       q_valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [CW-1:0]    count_q;

  // Reset and flush share one result. A disabled cycle also clears when the
  // block is not in hold mode, which reproduces the legacy flop behaviour.
  logic clear;
  assign clear = rst | flush | (~en & ~HOLD_MODE);

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= RESET_VAL;
      end
      vld_q   <= '0;
      count_q <= '0;
    end else if (en) begin
      data_q[0] <= d;
      vld_q[0]  <= d_valid;
      for (int i = 1; i < DEPTH; i++) begin
        data_q[i] <= data_q[i-1];
        vld_q[i]  <= vld_q[i-1];
      end
      // Net change uses the pre-edge values: the incoming word adds one, and
      // the word leaving the last stage removes one. The count therefore stays
      // within 0..DEPTH, so the unsigned arithmetic cannot wrap.
      count_q <= count_q + CW'(d_valid) - CW'(vld_q[DEPTH-1]);
    end
    // en=0 in hold mode: every register keeps its value.
  end

  assign q       = data_q[DEPTH-1];
  assign q_valid = vld_q[DEPTH-1];
  assign count   = count_q;

endmodule
